// File: rtl/uart1_rx_if.sv
// ============================================================================
// Module      : uart1_rx_if
// Description : Serial line input and received-byte outputs of uart1_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart1_rx_if;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    modport master (
        output RxD,
        input  data,
        input  data_valid,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  RxD,
        output data,
        output data_valid,
        output framing_error,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/uart1_rx.sv
// ============================================================================
// Module      : uart1_rx
// Description : 8N1 UART receiver, oversampled with 3-sample majority vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart1_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input wire          clk,
    input wire          reset,
    uart1_rx_if.slave   rx
);

    localparam int c_div  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_divw = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_tw   = $clog2(OVERSAMPLE);
    localparam int c_mid  = OVERSAMPLE / 2;

    localparam logic [c_divw-1:0] c_div_last = c_divw'(c_div - 1);
    localparam logic [c_divw-1:0] c_div_one  = c_divw'(1);
    localparam logic [c_tw-1:0]   c_t_m1     = c_tw'(c_mid - 1);
    localparam logic [c_tw-1:0]   c_t_m      = c_tw'(c_mid);
    localparam logic [c_tw-1:0]   c_t_p1     = c_tw'(c_mid + 1);
    localparam logic [c_tw-1:0]   c_t_last   = c_tw'(OVERSAMPLE - 1);
    localparam logic [c_tw-1:0]   c_t_one    = c_tw'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_break = 3'd4;

    if (c_div < 1) begin : g_div_check
        $error("uart1_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if (OVERSAMPLE < 12) begin : g_os_check
        $error("uart1_rx: OVERSAMPLE must be at least 12");
    end

    logic              r_sync1;
    logic              r_rx_s;
    logic [2:0]        r_state;
    logic [c_divw-1:0] r_div;
    logic [c_tw-1:0]   r_tcnt;
    logic [2:0]        r_bcnt;
    logic [1:0]        r_smp;
    logic [7:0]        r_shreg;
    logic [7:0]        r_data;
    logic              r_dv;
    logic              r_fe;

    logic w_running;
    logic w_tick;
    logic w_decide;
    logic w_bit_end;
    logic w_maj;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx.RxD;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_running = (r_state != c_st_idle);
    assign w_tick    = w_running && (r_div == c_div_last);
    assign w_decide  = w_tick && (r_tcnt == c_t_p1);
    assign w_bit_end = w_tick && (r_tcnt == c_t_last);

    // Third vote is the live sample on the decision tick itself.
    assign w_maj = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rx_s) | (r_smp[1] & r_rx_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_tcnt <= '0;
            r_bcnt <= '0;
        end else if (!w_running) begin
            r_div  <= '0;
            r_tcnt <= '0;
            r_bcnt <= '0;
        end else begin
            if (w_tick) begin
                r_div  <= '0;
                r_tcnt <= (r_tcnt == c_t_last) ? '0 : r_tcnt + c_t_one;
            end else begin
                r_div  <= r_div + c_div_one;
            end
            if ((r_state == c_st_data) && w_bit_end) begin
                r_bcnt <= r_bcnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_smp <= 2'b11;
        end else if (w_tick) begin
            if (r_tcnt == c_t_m1) r_smp[0] <= r_rx_s;
            if (r_tcnt == c_t_m)  r_smp[1] <= r_rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_shreg <= '0;
            r_data  <= '0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_fe <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (!r_rx_s) r_state <= c_st_start;
                end
                c_st_start: begin
                    if (w_decide && w_maj) begin
                        r_state <= c_st_idle;
                    end else if (w_bit_end) begin
                        r_state <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_decide) begin
                        r_shreg <= {w_maj, r_shreg[7:1]};
                    end
                    if (w_bit_end && (r_bcnt == 3'd7)) begin
                        r_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    // Decide mid-stop-bit so a back-to-back start edge is not missed.
                    if (w_decide) begin
                        if (w_maj) begin
                            r_data  <= r_shreg;
                            r_dv    <= 1'b1;
                            r_state <= c_st_idle;
                        end else begin
                            r_fe    <= 1'b1;
                            r_state <= c_st_break;
                        end
                    end
                end
                c_st_break: begin
                    if (r_rx_s) r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rx.data          = r_data;
    assign rx.data_valid    = r_dv;
    assign rx.framing_error = r_fe;
    assign rx.busy          = w_running;

endmodule

`default_nettype wire
